layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NEURON_NUM, default 30, number of parallel neuron results gathered per inference.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bit width of each neuron result.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port layer_in, input, NEURON_NUM*DATA_WIDTH, neuron n result in bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port layer_in_valid, input, NEURON_NUM, neuron n result-valid pulse, one cycle, independent per neuron.
REQ-007 SHALL have port stall, input, 1, downstream hold request; while high, no new element is issued.
REQ-008 SHALL have port clr_overrun, input, 1, clears the sticky overrun flag.
REQ-009 SHALL have port seq_output, output, DATA_WIDTH, serialized element for the next layer input.
REQ-010 SHALL have port seq_output_valid, output, 1, qualifies seq_output for one cycle per element.
REQ-011 SHALL have port seq_last, output, 1, high together with seq_output_valid on element NEURON_NUM-1.
REQ-012 SHALL have port seq_idx, output, $clog2(NEURON_NUM), index of the element on seq_output.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse in the cycle after seq_last.
REQ-015 SHALL have port overrun, output, 1, sticky flag for a result that arrived while the buffer was locked and was dropped.

Function
REQ-016 SHALL implement states IDLE, COLLECT, SEND and DONE.
REQ-017 In IDLE and COLLECT, a high layer_in_valid[n] SHALL latch layer_in slice n into buffer slot n and set pending bit n.
REQ-018 IDLE SHALL go to COLLECT on any valid bit when the mask does not become full, and directly to SEND when the mask becomes full.
REQ-019 COLLECT SHALL go to SEND in the cycle after the cycle in which the pending mask becomes all ones, counting the bits set in that same cycle.
REQ-020 A repeat valid on an already-set pending bit in COLLECT SHALL overwrite slot n; the last value wins and no overrun is raised.
REQ-021 In SEND, when stall is low, the block SHALL drive seq_output = slot[idx], seq_output_valid = 1 and seq_idx = idx, then increment idx.
REQ-022 In SEND, when stall is high, seq_output_valid SHALL be 0 and idx SHALL hold.
REQ-023 In SEND, the issue for idx = NEURON_NUM-1 SHALL assert seq_last; the next state SHALL be DONE.
REQ-024 DONE SHALL last one cycle: done = 1, pending mask cleared, idx = 0, next state IDLE.
REQ-025 Latency: with no stall, if the mask completes in cycle T, elements SHALL issue in cycles T+1 through T+NEURON_NUM, and done SHALL pulse at T+NEURON_NUM+1.
REQ-026 Any layer_in_valid bit in SEND or DONE SHALL be dropped and SHALL set overrun; buffer contents are unchanged.
REQ-027 clr_overrun SHALL clear overrun; if an overrun event occurs in the same cycle, set wins.
REQ-028 seq_output SHALL be registered; when seq_output_valid = 0 its value is don't-care but stable.
REQ-029 The idx counter SHALL never exceed NEURON_NUM-1; no wrap occurs within SEND.

Reset
REQ-030 While rst_n = 0 at a clock edge, the block SHALL force: state IDLE, pending mask 0, idx 0, seq_output 0, seq_output_valid 0, seq_last 0, seq_idx 0, busy 0, done 0, overrun 0.
REQ-031 Buffer slots need not be reset.
REQ-032 Reset asserted mid-COLLECT or mid-SEND SHALL abort the sequence with no done pulse.

Structure
REQ-033 A shared package SHALL hold the state enumeration and the index-width function, for reuse by the other layer sequencers.
REQ-034 The design SHALL be a single module with no sub-modules; the buffer is a register array indexed by idx.

Verification
REQ-035 Test 1: NEURON_NUM = 4, all valid bits pulse together in cycle T with slots 0x0011, 0x0022, 0x0033, 0x0044 -> seq_output = 0x0011..0x0044 in T+1..T+4, seq_idx = 0..3, seq_last in T+4, done in T+5.
REQ-036 Test 2: valids staggered (bit 2 at T, bit 0 at T+3, bit 3 at T+5, bit 1 at T+9) -> state is COLLECT until T+9, first element at T+10, order is by index, not by arrival.
REQ-037 Test 3: stall high in cycles T+2..T+4 of SEND -> no valid in those cycles, elements contiguous and lossless, seq_last delayed by 3 cycles.
REQ-038 Test 4: layer_in_valid[1] pulses during SEND -> overrun = 1 and stays 1, the stream is unchanged; then clr_overrun pulse -> overrun = 0.
REQ-039 Test 5: rst_n low for one cycle after 2 elements -> all outputs 0 the next cycle, no done pulse, a fresh full capture then streams normally.
REQ-040 Test 6: slot 1 written twice in COLLECT (0x1111 then 0x2222) -> element 1 = 0x2222, overrun = 0.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Shared types and sizing helpers for the layer sequencer family.
// Gathers the state enumeration and index-width function in one place.
package layer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  // A single-element layer still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Gathers per-neuron results into a buffer, then streams them out in index order
// as a serialized input for the next layer.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NEURON_NUM = 30,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NEURON_NUM*DATA_WIDTH-1:0] layer_in,
  input  logic [NEURON_NUM-1:0]            layer_in_valid,
  input  logic                             stall,
  input  logic                             clr_overrun,
  output logic [DATA_WIDTH-1:0]            seq_output,
  output logic                             seq_output_valid,
  output logic                             seq_last,
  output logic [idx_width(NEURON_NUM)-1:0] seq_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun
);

  localparam int            IW       = idx_width(NEURON_NUM);
  localparam logic [IW-1:0] LAST_IDX = IW'(NEURON_NUM - 1);

  seq_state_e            state_q;
  logic [NEURON_NUM-1:0] pending_q;
  logic [NEURON_NUM-1:0] pending_d;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] slot_q [NEURON_NUM];
  logic [DATA_WIDTH-1:0] seq_output_q;
  logic                  seq_output_valid_q;
  logic                  seq_last_q;
  logic [IW-1:0]         seq_idx_q;
  logic                  done_q;
  logic                  overrun_q;
  logic                  accept;
  logic                  drop;

  always_comb begin
    accept    = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    pending_d = pending_q | layer_in_valid;
    drop      = !accept && (|layer_in_valid);
  end

  // The buffer is locked from mask completion until the sequence returns to IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int n = 0; n < NEURON_NUM; n++) begin
        if (layer_in_valid[n]) begin
          slot_q[n] <= layer_in[n*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      pending_q          <= '0;
      idx_q              <= '0;
      seq_output_q       <= '0;
      seq_output_valid_q <= 1'b0;
      seq_last_q         <= 1'b0;
      seq_idx_q          <= '0;
      done_q             <= 1'b0;
      overrun_q          <= 1'b0;
    end else begin
      seq_output_valid_q <= 1'b0;
      seq_last_q         <= 1'b0;
      done_q             <= 1'b0;

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          pending_q <= pending_d;
          if (&pending_d) begin
            state_q <= ST_SEND;
          end else if (|layer_in_valid) begin
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          pending_q <= pending_d;
          if (&pending_d) begin
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!stall) begin
            seq_output_q       <= slot_q[idx_q];
            seq_output_valid_q <= 1'b1;
            seq_idx_q          <= idx_q;
            // idx parks on the last slot; DONE rewinds it.
            if (idx_q == LAST_IDX) begin
              seq_last_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_q    <= 1'b1;
          pending_q <= '0;
          idx_q     <= '0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign seq_output       = seq_output_q;
  assign seq_output_valid = seq_output_valid_q;
  assign seq_last         = seq_last_q;
  assign seq_idx          = seq_idx_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer with four neurons: directed vector table,
// hand-written corner sequences, and a randomized run against a scoreboard model.
module tb_layer_sequencer;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] layer_in;
  logic [N-1:0]   layer_in_valid;
  logic           stall;
  logic           clr_overrun;
  logic [W-1:0]   seq_output;
  logic           seq_output_valid;
  logic           seq_last;
  logic [1:0]     seq_idx;
  logic           busy;
  logic           done;
  logic           overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.NEURON_NUM(N), .DATA_WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .layer_in         (layer_in),
    .layer_in_valid   (layer_in_valid),
    .stall            (stall),
    .clr_overrun      (clr_overrun),
    .seq_output       (seq_output),
    .seq_output_valid (seq_output_valid),
    .seq_last         (seq_last),
    .seq_idx          (seq_idx),
    .busy             (busy),
    .done             (done),
    .overrun          (overrun)
  );

  typedef struct {
    logic [3:0]  v;
    logic [63:0] d;
    logic        st;
    logic        ev;
    logic [15:0] eo;
    logic [1:0]  ei;
    logic        el;
    logic        ed;
    logic        eb;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic [3:0] v, input logic [63:0] d, input logic st,
                      input logic cl, input logic rn);
    layer_in_valid = v;
    layer_in       = d;
    stall          = st;
    clr_overrun    = cl;
    rst_n          = rn;
    @(negedge clk);
  endtask

  task automatic stream_check(input logic [15:0] e [4], input int inj_at, input string tag);
    for (int k = 0; k < N; k++) begin
      step((inj_at == k) ? 4'b0010 : 4'b0000, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b1);
      chk({tag, "_valid"}, 32'(seq_output_valid), 32'd1);
      chk({tag, "_out"}, 32'(seq_output), 32'(e[k]));
      chk({tag, "_idx"}, 32'(seq_idx), k);
      chk({tag, "_last"}, 32'(seq_last), 32'(k == N - 1));
      chk({tag, "_ovr"}, 32'(overrun), 32'(inj_at >= 0 && k >= inj_at));
    end
    step(4'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_valid"}, 32'(seq_output_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    step(4'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    $display("%s: stream %h %h %h %h checked", tag, e[0], e[1], e[2], e[3]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e [4];
    logic [63:0] d;
    logic [15:0] m_slot [4];
    logic [3:0]  m_mask;
    bit          locked;
    int          sent;
    bit          m_ov;
    bit          done_pend;
    int          streams;

    // Test 1 (rows 0-6) and Test 3 with stall over three SEND cycles (rows 7-15).
    tbl[0]  = '{4'hF, 64'h0044_0033_0022_0011, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0011, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0022, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0033, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0044, 2'd3, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{4'h0, 64'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{4'h0, 64'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'hF, 64'h0d04_0c03_0b02_0a01, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0a01, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{4'h0, 64'h0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{4'h0, 64'h0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{4'h0, 64'h0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0b02, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0c03, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h0d04, 2'd3, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{4'h0, 64'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0};

    // Reset state.
    layer_in = '0; layer_in_valid = '0; stall = 1'b0; clr_overrun = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    step(4'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(seq_output_valid), 32'd0);
    chk("rst_out", 32'(seq_output), 32'd0);
    chk("rst_idx", 32'(seq_idx), 32'd0);
    chk("rst_last", 32'(seq_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    for (int r = 0; r < 16; r++) begin
      step(tbl[r].v, tbl[r].d, tbl[r].st, 1'b0, 1'b1);
      chk($sformatf("vec%0d_valid", r), 32'(seq_output_valid), 32'(tbl[r].ev));
      chk($sformatf("vec%0d_last", r), 32'(seq_last), 32'(tbl[r].el));
      chk($sformatf("vec%0d_done", r), 32'(done), 32'(tbl[r].ed));
      chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].eb));
      chk($sformatf("vec%0d_ovr", r), 32'(overrun), 32'd0);
      if (tbl[r].ev) begin
        chk($sformatf("vec%0d_out", r), 32'(seq_output), 32'(tbl[r].eo));
        chk($sformatf("vec%0d_idx", r), 32'(seq_idx), 32'(tbl[r].ei));
      end
      $display("vec %0d: v=%h stall=%b valid=%b out=%h idx=%0d last=%b done=%b busy=%b",
               r, tbl[r].v, tbl[r].st, seq_output_valid, seq_output, seq_idx, seq_last, done, busy);
    end

    // Test 2: staggered arrivals; output order follows index, not arrival.
    for (int off = 0; off < 10; off++) begin
      logic [3:0] v;
      d = {$urandom(), $urandom()};
      v = 4'b0;
      case (off)
        0: v = 4'b0100;
        3: v = 4'b0001;
        5: v = 4'b1000;
        9: v = 4'b0010;
        default: v = 4'b0;
      endcase
      for (int n = 0; n < N; n++) if (v[n]) e[n] = d[n*W +: W];
      step(v, d, 1'b0, 1'b0, 1'b1);
      chk($sformatf("t2_busy%0d", off), 32'(busy), 32'd1);
      chk($sformatf("t2_novalid%0d", off), 32'(seq_output_valid), 32'd0);
    end
    stream_check(e, -1, "t2");

    // Test 4: late result during SEND is dropped and flagged; clr_overrun clears it.
    d = {$urandom(), $urandom()};
    for (int n = 0; n < N; n++) e[n] = d[n*W +: W];
    step(4'hF, d, 1'b0, 1'b0, 1'b1);
    stream_check(e, 1, "t4");
    chk("t4_ovr_sticky", 32'(overrun), 32'd1);
    step(4'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("t4_ovr_hold", 32'(overrun), 32'd1);
    step(4'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    chk("t4_ovr_clr", 32'(overrun), 32'd0);

    // Test 5: reset after two elements aborts the sequence without done.
    d = {$urandom(), $urandom()};
    step(4'hF, d, 1'b0, 1'b0, 1'b1);
    step(4'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_e0", 32'(seq_output), 32'(d[15:0]));
    step(4'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("t5_e1", 32'(seq_output), 32'(d[31:16]));
    step(4'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_rst_valid", 32'(seq_output_valid), 32'd0);
    chk("t5_rst_out", 32'(seq_output), 32'd0);
    chk("t5_rst_idx", 32'(seq_idx), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step(4'b0, 64'd0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("t5_nodone%0d", c), 32'(done), 32'd0);
      chk($sformatf("t5_idle%0d", c), 32'(busy | seq_output_valid), 32'd0);
    end
    d = {$urandom(), $urandom()};
    for (int n = 0; n < N; n++) e[n] = d[n*W +: W];
    step(4'hF, d, 1'b0, 1'b0, 1'b1);
    stream_check(e, -1, "t5");

    // Test 6: repeat write of slot 1 in COLLECT, last value wins, no overrun.
    d = {$urandom(), $urandom()};
    d[31:16] = 16'h1111;
    step(4'b0010, d, 1'b0, 1'b0, 1'b1);
    d[31:16] = 16'h2222;
    step(4'b0010, d, 1'b0, 1'b0, 1'b1);
    chk("t6_ovr", 32'(overrun), 32'd0);
    d = {$urandom(), $urandom()};
    e[0] = d[15:0]; e[1] = 16'h2222; e[2] = d[47:32]; e[3] = d[63:48];
    step(4'b1101, d, 1'b0, 1'b0, 1'b1);
    stream_check(e, -1, "t6");

    // Randomized run against a transaction-level scoreboard.
    m_mask = 4'b0; locked = 0; sent = 0; m_ov = 0; done_pend = 0; streams = 0;
    for (int n = 0; n < N; n++) m_slot[n] = 16'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [3:0] v;
      logic       st;
      logic       cl;
      bit         send_act;
      bit         dropped;
      bit         exp_v;
      bit         exp_l;
      bit         ov_exp;
      d  = {$urandom(), $urandom()};
      v  = 4'b0;
      if (locked) begin
        if ($urandom_range(0, 15) == 0) v = 4'($urandom_range(1, 15));
      end else begin
        for (int n = 0; n < N; n++) v[n] = ($urandom_range(0, 3) == 0);
      end
      st = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 7) == 0);
      send_act = locked && (sent < N);
      dropped  = locked && (v != 4'b0);
      if (!locked) begin
        for (int n = 0; n < N; n++) if (v[n]) m_slot[n] = d[n*W +: W];
        m_mask = m_mask | v;
        if (m_mask == 4'hF) locked = 1;
      end
      ov_exp = dropped || (m_ov && !cl);
      step(v, d, st, cl, 1'b1);

      exp_v = send_act && !st;
      exp_l = 0;
      chk("rnd_valid", 32'(seq_output_valid), 32'(exp_v));
      chk("rnd_done", 32'(done), 32'(done_pend));
      if (exp_v) begin
        chk("rnd_out", 32'(seq_output), 32'(m_slot[sent]));
        chk("rnd_idx", 32'(seq_idx), sent);
        exp_l = (sent == N - 1);
        sent++;
      end
      chk("rnd_last", 32'(seq_last), 32'(exp_l));
      if (done_pend) begin
        locked = 0;
        m_mask = 4'b0;
        sent   = 0;
        streams++;
        $display("rnd: stream %0d finished at cycle %0d", streams, cyc);
      end
      done_pend = exp_l;
      chk("rnd_ovr", 32'(overrun), 32'(ov_exp));
      m_ov = ov_exp;
      chk("rnd_busy", 32'(busy), 32'(locked || (m_mask != 4'b0)));
    end
    chk("rnd_streams_seen", 32'(streams > 5), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
